// File: rtl/dct_pkg.sv
// Shared definitions for the 2-D DCT sequencing slice: size codes, lane geometry and FSM states.
package dct_pkg;

   localparam int DCT_W       = 16;
   localparam int DCT_MAX_PTS = 32;

   localparam logic [1:0] DCT_N4  = 2'd0;
   localparam logic [1:0] DCT_N8  = 2'd1;
   localparam logic [1:0] DCT_N16 = 2'd2;
   localparam logic [1:0] DCT_N32 = 2'd3;

   typedef enum logic [1:0] {IDLE, ROW, COL, DONE} dct_state_e;

   function automatic int dct_size(input logic [1:0] n);
      case (n)
         DCT_N4:  return 4;
         DCT_N8:  return 8;
         DCT_N16: return 16;
         DCT_N32: return 32;
         default: return 4;
      endcase
   endfunction

endpackage

// File: rtl/dct2_2d_ctrl_if.sv
// Row-in / column-out streaming handshake of the 2-D DCT controller.
interface dct2_2d_ctrl_if #(
   parameter int W       = dct_pkg::DCT_W,
   parameter int MAX_PTS = dct_pkg::DCT_MAX_PTS
);

   logic                   in_valid;
   logic                   in_ready;
   logic [1:0]             in_n;
   logic [W*MAX_PTS-1:0]   in_x;
   logic                   out_valid;
   logic                   out_ready;
   logic [W*MAX_PTS-1:0]   out_y;
   logic                   out_last;

   modport master (
      output in_valid, in_n, in_x, out_ready,
      input  in_ready, out_valid, out_y, out_last
   );

   modport slave (
      input  in_valid, in_n, in_x, out_ready,
      output in_ready, out_valid, out_y, out_last
   );

endinterface

// File: rtl/dct2_transpose_buf.sv
// Transpose store between the two engine passes: rows written whole, columns read combinationally.
module dct2_transpose_buf
   import dct_pkg::*;
#(
   parameter  int W       = DCT_W,
   parameter  int MAX_PTS = DCT_MAX_PTS,
   localparam int IW      = $clog2(MAX_PTS)
) (
   input  logic                 clk,
   input  logic [1:0]           n,
   input  logic                 wr_en,
   input  logic [IW-1:0]        wr_row,
   input  logic [W*MAX_PTS-1:0] wr_data,
   input  logic [IW-1:0]        rd_col,
   output logic [W*MAX_PTS-1:0] rd_data
);

   logic [W-1:0] mem [MAX_PTS][MAX_PTS];

   // Only the active S lanes of a row are kept; the rest are left untouched.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int c = 0; c < MAX_PTS; c++) begin
            if (c < dct_size(n))
               mem[wr_row][c] <= wr_data[W*c +: W];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int r = 0; r < MAX_PTS; r++) begin
         if (r < dct_size(n))
            rd_data[W*r +: W] = mem[r][rd_col];
      end
   end

endmodule

// File: rtl/dct2_2d_ctrl.sv
// Runs one shared 1-D DCT engine over rows, then over the transposed columns, for a full 2-D block.
//  state | meaning
//  IDLE  | waiting for the first row; its size code fixes the block size
//  ROW   | accepting rows 1..S-1 into the transpose buffer
//  COL   | feeding buffer columns to the engine and registering results
//  DONE  | holding the last column until the quantiser takes it
module dct2_2d_ctrl
   import dct_pkg::*;
#(
   parameter int W       = DCT_W,
   parameter int MAX_PTS = DCT_MAX_PTS
) (
   input  logic                 clk,
   input  logic                 rst,
   dct2_2d_ctrl_if.slave        bus,
   output logic                 busy,
   output logic [W*MAX_PTS-1:0] dct_x,
   output logic [1:0]           dct_n,
   input  logic [W*MAX_PTS-1:0] dct_y
);

   localparam int IW = $clog2(MAX_PTS);
   localparam int VW = W*MAX_PTS;

   dct_state_e      state;
   logic [IW-1:0]   row_idx;
   logic [IW-1:0]   col_idx;
   logic [1:0]      n_reg;
   logic            out_valid_q;
   logic            out_last_q;
   logic [VW-1:0]   out_y_q;
   logic [VW-1:0]   col_data;
   logic [VW-1:0]   lane_mask;
   logic [IW-1:0]   wr_row;
   logic            in_ready;
   logic            in_hs;
   logic            load;
   logic            last_row;
   logic            last_col;
   int              size;

   always_comb begin
      size      = dct_size(n_reg);
      in_ready  = (state == IDLE) || (state == ROW);
      in_hs     = bus.in_valid && in_ready;
      load      = (state == COL) && (!out_valid_q || bus.out_ready);
      last_row  = (int'(row_idx) == size - 1);
      last_col  = (int'(col_idx) == size - 1);
      dct_n     = (state == IDLE) ? bus.in_n : n_reg;
      dct_x     = (state == COL) ? col_data : bus.in_x;
      wr_row    = (state == IDLE) ? '0 : row_idx;
      busy      = (state != IDLE);
      lane_mask = '0;
      for (int k = 0; k < MAX_PTS; k++) begin
         if (k < size)
            lane_mask[W*k +: W] = '1;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_y     = out_y_q;
   assign bus.out_last  = out_last_q;

   dct2_transpose_buf #(
      .W       (W),
      .MAX_PTS (MAX_PTS)
   ) u_buf (
      .clk     (clk),
      .n       (dct_n),
      .wr_en   (in_hs),
      .wr_row  (wr_row),
      .wr_data (dct_y),
      .rd_col  (col_idx),
      .rd_data (col_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         row_idx     <= '0;
         col_idx     <= '0;
         n_reg       <= DCT_N4;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_last_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_hs) begin
                  n_reg   <= bus.in_n;
                  row_idx <= 1'b1;
                  state   <= ROW;
               end
            end
            ROW: begin
               if (in_hs) begin
                  if (last_row) begin
                     row_idx <= '0;
                     state   <= COL;
                  end else begin
                     row_idx <= row_idx + 1'b1;
                  end
               end
            end
            COL: begin
               // A new column loads whenever the previous one is gone or leaving this cycle.
               if (load) begin
                  out_y_q     <= dct_y & lane_mask;
                  out_valid_q <= 1'b1;
                  out_last_q  <= last_col;
                  if (last_col) begin
                     col_idx <= '0;
                     state   <= DONE;
                  end else begin
                     col_idx <= col_idx + 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dct2_2d_ctrl.sv
// Randomised bench for dct2_2d_ctrl with a lane-tagging engine stub and an arithmetic 2-D reference.
module tb_dct2_2d_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         busy;
   logic [511:0] dct_x;
   logic [1:0]   dct_n;
   logic [511:0] dct_y;
   bit           ident;
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   int           t0;
   int           tfv;
   logic [15:0]  xm [32][32];

   dct2_2d_ctrl_if bus ();

   dct2_2d_ctrl dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .busy  (busy),
      .dct_x (dct_x),
      .dct_n (dct_n),
      .dct_y (dct_y)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Engine stub: identity, or each active lane k tagged with k+1 plus the size code; idle lanes get garbage.
   always_comb begin
      dct_y = '0;
      for (int k = 0; k < 32; k++) begin
         if (ident)
            dct_y[16*k +: 16] = dct_x[16*k +: 16];
         else if (k < (4 << dct_n))
            dct_y[16*k +: 16] = dct_x[16*k +: 16] + 16'(k + 1) + (16'(dct_n) << 8);
         else
            dct_y[16*k +: 16] = 16'hdead;
      end
   end

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Two passes of the stub add (c+1+n*256) then (r+1+n*256) to element (r,c).
   function automatic logic [511:0] exp_col(input int n, input int c);
      logic [511:0] v;
      v = '0;
      for (int r = 0; r < (4 << n); r++) begin
         if (ident) v[16*r +: 16] = xm[r][c];
         else       v[16*r +: 16] = xm[r][c] + 16'(r + c + 2) + 16'(n << 9);
      end
      return v;
   endfunction

   task automatic fill(input bit ramp);
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            xm[r][c] = ramp ? 16'(4*r + c) : 16'($urandom);
   endtask

   task automatic send_rows(input int n, input int gap, input bit tog);
      int s;
      int to;
      logic [511:0] v;
      s = 4 << n;
      for (int r = 0; r < s; r++) begin
         if (gap > 0) begin
            bus.in_valid = 1'b0;
            bus.in_n     = 2'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
         end
         for (int k = 0; k < 32; k++)
            v[16*k +: 16] = (k < s) ? xm[r][k] : 16'($urandom);
         bus.in_x     = v;
         bus.in_n     = (r == 0) ? 2'(n) : (tog ? 2'd3 : 2'($urandom_range(0, 3)));
         bus.in_valid = 1'b1;
         to = 0;
         while (!bus.in_ready && to < 400) begin
            @(negedge clk);
            to++;
         end
         if (to >= 400) chk("in_timeout", 512'd0, 512'd1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic collect(input int n, input int sc, input int sl, input int ncols);
      int s;
      int to;
      s = 4 << n;
      for (int c = 0; c < ncols; c++) begin
         to = 0;
         while (!bus.out_valid && to < 400) begin
            @(negedge clk);
            to++;
         end
         if (to >= 400) chk("out_timeout", 512'd0, 512'd1);
         if (c == 0) tfv = cyc;
         chk("in_ready_col", 512'(bus.in_ready), 512'd0);
         chk("busy_col", 512'(busy), 512'd1);
         if (c == sc && sl > 0) begin
            bus.out_ready = 1'b0;
            for (int k = 0; k < sl; k++) begin
               @(negedge clk);
               chk("stall_valid", 512'(bus.out_valid), 512'd1);
               chk("stall_y", bus.out_y, exp_col(n, c));
            end
            bus.out_ready = 1'b1;
         end
         chk("col_y", bus.out_y, exp_col(n, c));
         chk("col_last", 512'(bus.out_last), 512'(c == s - 1));
         @(negedge clk);
      end
   endtask

   task automatic run_block(input int n, input bit id, input int gap, input bit tog,
                            input int sc, input int sl, input bit timed);
      int s;
      s     = 4 << n;
      ident = id;
      t0    = cyc;
      fork
         send_rows(n, gap, tog);
         collect(n, sc, sl, s);
      join
      chk("busy_end", 512'(busy), 512'd0);
      chk("valid_end", 512'(bus.out_valid), 512'd0);
      chk("in_ready_end", 512'(bus.in_ready), 512'd1);
      if (timed) begin
         chk("latency", 512'(tfv - t0 - 1), 512'(s));
         chk("block_cycles", 512'(cyc - t0), 512'(2*s + 1));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst           = 1'b1;
      ident         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_n      = 2'd0;
      bus.in_x      = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 512'(busy), 512'd0);
      chk("rst_valid", 512'(bus.out_valid), 512'd0);
      chk("rst_y", bus.out_y, 512'd0);
      chk("rst_last", 512'(bus.out_last), 512'd0);
      chk("rst_in_ready", 512'(bus.in_ready), 512'd1);

      fill(1'b1);
      run_block(0, 1'b1, 0, 1'b0, -1, 0, 1'b1);

      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            xm[r][c] = '0;
      run_block(3, 1'b1, 0, 1'b0, -1, 0, 1'b1);

      fill(1'b0);
      run_block(1, 1'b0, 0, 1'b0, 3, 5, 1'b0);

      fill(1'b0);
      run_block(2, 1'b0, 0, 1'b1, -1, 0, 1'b1);

      // Abort mid-COL: two columns taken, third already loaded.
      fill(1'b0);
      ident = 1'b0;
      fork
         send_rows(0, 0, 1'b0);
         collect(0, -1, 0, 2);
      join
      chk("pre_abort_busy", 512'(busy), 512'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 512'(busy), 512'd0);
      chk("abort_valid", 512'(bus.out_valid), 512'd0);
      chk("abort_y", bus.out_y, 512'd0);
      chk("abort_in_ready", 512'(bus.in_ready), 512'd1);
      fill(1'b0);
      run_block(0, 1'b0, 0, 1'b0, -1, 0, 1'b1);

      fill(1'b1);
      run_block(0, 1'b1, 3, 1'b0, -1, 0, 1'b0);

      for (int b = 0; b < 8; b++) begin
         n = $urandom_range(0, 3);
         fill(1'b0);
         run_block(n, 1'b0, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   $urandom_range(0, (4 << n) - 1), $urandom_range(0, 4), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
